usb_rx_controller: RTL and testbench



---
 rtl/usb_rx_controller.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_usb_rx_controller.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_controller.sv
// usb_rx_controller: receive-side bit-layer sequencer.
// Gates the NRZI decoder for the span of one packet, validates SYNC, strips
// stuffed bits, assembles LSB-first bytes and reports EOP or an error code.
module usb_rx_controller #(
    parameter int MAX_BYTES = 1027,
    parameter int IDLE_BITS = 8
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic       rx_enable,
    input  logic       pulse,
    input  logic       rx_dp,
    input  logic       rx_se0,
    input  logic       decoded_bit,
    output logic       dec_en,
    output logic       dec_bit,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_active,
    output logic       rx_eop,
    output logic       rx_err,
    output logic [1:0] err_code
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SYNC  = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_EOP   = 3'd3;
    localparam logic [2:0] ST_ERROR = 3'd4;

    localparam logic [1:0] ERR_SYNC    = 2'd0;
    localparam logic [1:0] ERR_STUFF   = 2'd1;
    localparam logic [1:0] ERR_PARTIAL = 2'd2;
    localparam logic [1:0] ERR_BABBLE  = 2'd3;

    localparam int BCW = $clog2(MAX_BYTES + 2);
    localparam int ICW = $clog2(IDLE_BITS + 1);

    // Registered state
    logic [2:0]     state_r;
    logic [2:0]     zcnt_r;
    logic [2:0]     bit_cnt_r;
    logic [2:0]     ones_cnt_r;
    logic [BCW-1:0] byte_cnt_r;
    logic [ICW-1:0] jcnt_r;
    // Holds the up-to-7 bits already received of the current byte; the
    // 8th bit is concatenated on top when the byte completes.
    logic [6:0]     shreg_r;
    logic           stb_d1_r;
    logic           stb_d2_r;

    // Next-state values
    logic [2:0]     state_s;
    logic [2:0]     zcnt_s;
    logic [2:0]     bit_cnt_s;
    logic [2:0]     ones_cnt_s;
    logic [BCW-1:0] byte_cnt_s;
    logic [ICW-1:0] jcnt_s;
    logic [6:0]     shreg_s;
    logic           dec_en_s;
    logic           dec_bit_s;
    logic [7:0]     rx_data_s;
    logic           rx_valid_s;
    logic           rx_active_s;
    logic           rx_eop_s;
    logic           rx_err_s;
    logic [1:0]     err_code_s;

    // Line events and error request
    logic           pls_se0_s;
    logic           pls_data_s;
    logic           pls_j_s;
    logic           pls_k_s;
    logic           bit_stb_s;
    logic           err_go_s;
    logic [1:0]     err_sel_s;

    // Classify the current line sample; SE0 overrides the differential level
    always_comb begin
        pls_se0_s  = pulse & rx_se0;
        pls_data_s = pulse & ~rx_se0;
        pls_j_s    = pulse & ~rx_se0 & rx_dp;
        pls_k_s    = pulse & ~rx_se0 & ~rx_dp;
        bit_stb_s  = stb_d2_r;
    end

    // Delay fed-bit pulses by two clocks so decoded_bit is sampled once settled
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            stb_d1_r <= 1'b0;
            stb_d2_r <= 1'b0;
        end else if (!rx_enable) begin
            stb_d1_r <= 1'b0;
            stb_d2_r <= 1'b0;
        end else begin
            stb_d1_r <= pls_data_s & (dec_en | ((state_r == ST_IDLE) & ~rx_dp));
            stb_d2_r <= stb_d1_r;
        end
    end

    // Sequencer next-state and output computation
    always_comb begin
        state_s     = state_r;
        zcnt_s      = zcnt_r;
        bit_cnt_s   = bit_cnt_r;
        ones_cnt_s  = ones_cnt_r;
        byte_cnt_s  = byte_cnt_r;
        jcnt_s      = jcnt_r;
        shreg_s     = shreg_r;
        dec_en_s    = dec_en;
        dec_bit_s   = dec_bit;
        rx_data_s   = rx_data;
        rx_valid_s  = 1'b0;
        rx_active_s = rx_active;
        rx_eop_s    = 1'b0;
        rx_err_s    = 1'b0;
        err_code_s  = err_code;
        err_go_s    = 1'b0;
        err_sel_s   = ERR_SYNC;

        if (!rx_enable) begin
            // Silent abort: nothing is reported for a packet cut short here
            state_s     = ST_IDLE;
            dec_en_s    = 1'b0;
            dec_bit_s   = 1'b1;
            rx_active_s = 1'b0;
            zcnt_s      = 3'd0;
            bit_cnt_s   = 3'd0;
            ones_cnt_s  = 3'd0;
            byte_cnt_s  = {BCW{1'b0}};
            jcnt_s      = {ICW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pls_k_s) begin
                        // First K starts the decoder; it decodes as the first SYNC zero
                        state_s   = ST_SYNC;
                        dec_en_s  = 1'b1;
                        dec_bit_s = 1'b0;
                        zcnt_s    = 3'd0;
                    end else begin
                        dec_en_s  = 1'b0;
                        dec_bit_s = 1'b1;
                    end
                end
                ST_SYNC: begin
                    if (pls_se0_s) begin
                        err_go_s  = 1'b1;
                        err_sel_s = ERR_SYNC;
                    end else if (pls_data_s) begin
                        dec_bit_s = rx_dp;
                    end else if (bit_stb_s) begin
                        if (decoded_bit) begin
                            if (zcnt_r == 3'd7) begin
                                state_s     = ST_DATA;
                                rx_active_s = 1'b1;
                                bit_cnt_s   = 3'd0;
                                ones_cnt_s  = 3'd0;
                                byte_cnt_s  = {BCW{1'b0}};
                            end else begin
                                err_go_s  = 1'b1;
                                err_sel_s = ERR_SYNC;
                            end
                        end else if (zcnt_r == 3'd7) begin
                            // An eighth zero can never be a valid SYNC
                            err_go_s  = 1'b1;
                            err_sel_s = ERR_SYNC;
                        end else begin
                            zcnt_s = zcnt_r + 3'd1;
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_DATA: begin
                    if (pls_se0_s) begin
                        dec_en_s  = 1'b0;
                        dec_bit_s = 1'b1;
                        if (bit_cnt_r == 3'd0) begin
                            state_s = ST_EOP;
                        end else begin
                            err_go_s  = 1'b1;
                            err_sel_s = ERR_PARTIAL;
                        end
                    end else if (pls_data_s) begin
                        dec_bit_s = rx_dp;
                    end else if (bit_stb_s) begin
                        if (ones_cnt_r == 3'd6) begin
                            // Bit after six ones must be a stuffed zero
                            if (decoded_bit) begin
                                err_go_s  = 1'b1;
                                err_sel_s = ERR_STUFF;
                            end else begin
                                ones_cnt_s = 3'd0;
                            end
                        end else begin
                            shreg_s    = {decoded_bit, shreg_r[6:1]};
                            ones_cnt_s = decoded_bit ? (ones_cnt_r + 3'd1) : 3'd0;
                            if (bit_cnt_r == 3'd7) begin
                                bit_cnt_s = 3'd0;
                                if (byte_cnt_r == BCW'(MAX_BYTES)) begin
                                    err_go_s  = 1'b1;
                                    err_sel_s = ERR_BABBLE;
                                end else begin
                                    rx_data_s  = {decoded_bit, shreg_r};
                                    rx_valid_s = 1'b1;
                                    byte_cnt_s = byte_cnt_r + BCW'(1);
                                end
                            end else begin
                                bit_cnt_s = bit_cnt_r + 3'd1;
                            end
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_EOP: begin
                    dec_en_s  = 1'b0;
                    dec_bit_s = 1'b1;
                    if (pls_j_s) begin
                        state_s     = ST_IDLE;
                        rx_eop_s    = 1'b1;
                        rx_active_s = 1'b0;
                    end else if (pls_k_s) begin
                        err_go_s  = 1'b1;
                        err_sel_s = ERR_PARTIAL;
                    end else begin
                        state_s = ST_EOP;
                    end
                end
                ST_ERROR: begin
                    dec_en_s  = 1'b0;
                    dec_bit_s = 1'b1;
                    if (pls_j_s) begin
                        if (jcnt_r == ICW'(IDLE_BITS - 1)) begin
                            state_s = ST_IDLE;
                            jcnt_s  = {ICW{1'b0}};
                        end else begin
                            jcnt_s = jcnt_r + ICW'(1);
                        end
                    end else if (pulse) begin
                        // K or SE0 breaks the idle run
                        jcnt_s = {ICW{1'b0}};
                    end else begin
                        jcnt_s = jcnt_r;
                    end
                end
                default: begin
                    state_s     = ST_IDLE;
                    dec_en_s    = 1'b0;
                    dec_bit_s   = 1'b1;
                    rx_active_s = 1'b0;
                end
            endcase

            if (err_go_s) begin
                state_s     = ST_ERROR;
                rx_err_s    = 1'b1;
                err_code_s  = err_sel_s;
                rx_active_s = 1'b0;
                dec_en_s    = 1'b0;
                dec_bit_s   = 1'b1;
                jcnt_s      = {ICW{1'b0}};
            end else begin
                rx_err_s = 1'b0;
            end
        end
    end

    // Register sequencer state and all outputs
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_r    <= ST_IDLE;
            zcnt_r     <= 3'd0;
            bit_cnt_r  <= 3'd0;
            ones_cnt_r <= 3'd0;
            byte_cnt_r <= {BCW{1'b0}};
            jcnt_r     <= {ICW{1'b0}};
            shreg_r    <= 7'd0;
            dec_en     <= 1'b0;
            dec_bit    <= 1'b1;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            rx_active  <= 1'b0;
            rx_eop     <= 1'b0;
            rx_err     <= 1'b0;
            err_code   <= 2'd0;
        end else begin
            state_r    <= state_s;
            zcnt_r     <= zcnt_s;
            bit_cnt_r  <= bit_cnt_s;
            ones_cnt_r <= ones_cnt_s;
            byte_cnt_r <= byte_cnt_s;
            jcnt_r     <= jcnt_s;
            shreg_r    <= shreg_s;
            dec_en     <= dec_en_s;
            dec_bit    <= dec_bit_s;
            rx_data    <= rx_data_s;
            rx_valid   <= rx_valid_s;
            rx_active  <= rx_active_s;
            rx_eop     <= rx_eop_s;
            rx_err     <= rx_err_s;
            err_code   <= err_code_s;
        end
    end

endmodule

// File: tb/tb_usb_rx_controller.sv
// tb_usb_rx_controller: directed stimulus with a scoreboard queue of expected
// strobes (valid/eop/err) checked by an independent monitor.
module tb_usb_rx_controller;

    logic       clk = 1'b0;
    logic       nRST;
    logic       rx_enable;
    logic       pulse;
    logic       rx_dp;
    logic       rx_se0;
    logic       decoded_bit;
    logic       dec_en;
    logic       dec_bit;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_active;
    logic       rx_eop;
    logic       rx_err;
    logic [1:0] err_code;

    localparam logic [2:0] EV_VALID = 3'b001;
    localparam logic [2:0] EV_EOP   = 3'b010;
    localparam logic [2:0] EV_ERR   = 3'b100;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
        logic [1:0] code;
        int         ofs;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_pulse_cyc = 0;
    logic lvl;
    int   tx_ones;
    logic dec_last;

    always #5 clk = ~clk;

    usb_rx_controller #(.MAX_BYTES(2), .IDLE_BITS(8)) dut (
        .clk(clk), .nRST(nRST), .rx_enable(rx_enable), .pulse(pulse),
        .rx_dp(rx_dp), .rx_se0(rx_se0), .decoded_bit(decoded_bit),
        .dec_en(dec_en), .dec_bit(dec_bit), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_active(rx_active), .rx_eop(rx_eop),
        .rx_err(rx_err), .err_code(err_code)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // NRZI decoder model: no transition decodes as 1; idle reference is J
    always @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            dec_last    <= 1'b1;
            decoded_bit <= 1'b1;
        end else if (!dec_en) begin
            dec_last    <= 1'b1;
            decoded_bit <= 1'b1;
        end else begin
            decoded_bit <= (dec_bit == dec_last);
            dec_last    <= dec_bit;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input logic [2:0] k, input logic [7:0] d, input logic [1:0] c, input int o);
        exp_t e;
        e.kind = k;
        e.data = d;
        e.code = c;
        e.ofs  = o;
        exp_q.push_back(e);
    endtask

    // Monitor: every strobe must match the head of the expected queue
    initial begin
        exp_t mon_e;
        forever begin
            @(negedge clk);
            if (nRST && (rx_valid || rx_eop || rx_err)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 32'({rx_err, rx_eop, rx_valid}), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("strobe_kind", 32'({rx_err, rx_eop, rx_valid}), 32'(mon_e.kind));
                    if (mon_e.kind == EV_VALID) chk("rx_data", 32'(rx_data), 32'(mon_e.data));
                    if (mon_e.kind == EV_ERR) chk("err_code", 32'(err_code), 32'(mon_e.code));
                    chk("latency", 32'(cyc - last_pulse_cyc), 32'(mon_e.ofs));
                end
            end
        end
    end

    task automatic line_pulse(input logic se0, input logic dp);
        @(posedge clk);
        #1;
        pulse = 1'b1;
        rx_se0 = se0;
        rx_dp = dp;
        last_pulse_cyc = cyc;
        @(posedge clk);
        #1;
        pulse = 1'b0;
        rx_se0 = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic send_lvl(input logic l);
        lvl = l;
        line_pulse(1'b0, l);
    endtask

    task automatic send_dec(input logic b);
        logic nl;
        nl = b ? lvl : ~lvl;
        send_lvl(nl);
    endtask

    task automatic send_j_n(input int n);
        for (int i = 0; i < n; i++) send_lvl(1'b1);
    endtask

    task automatic send_sync();
        logic [7:0] pat;
        pat = 8'b0101_0100;  // K J K J K J K K, sent MSB first
        for (int i = 7; i >= 0; i--) send_lvl(pat[i]);
        tx_ones = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            send_dec(b[i]);
            if (b[i]) tx_ones++;
            else tx_ones = 0;
            if (tx_ones == 6) begin
                send_dec(1'b0);
                tx_ones = 0;
            end
        end
    endtask

    task automatic send_eop();
        line_pulse(1'b1, 1'b0);
        line_pulse(1'b1, 1'b0);
        send_lvl(1'b1);
    endtask

    task automatic good_packet(input logic [7:0] b0, input logic [7:0] b1);
        send_j_n(2);
        send_sync();
        expect_ev(EV_VALID, b0, 2'd0, 3);
        send_byte(b0);
        expect_ev(EV_VALID, b1, 2'd0, 3);
        send_byte(b1);
        expect_ev(EV_EOP, 8'h00, 2'd0, 1);
        send_eop();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dec_en"}, 32'(dec_en), 32'd0);
        chk({tag, "_dec_bit"}, 32'(dec_bit), 32'd1);
        chk({tag, "_rx_data"}, 32'(rx_data), 32'd0);
        chk({tag, "_rx_active"}, 32'(rx_active), 32'd0);
        chk({tag, "_err_code"}, 32'(err_code), 32'd0);
        chk({tag, "_strobes"}, 32'({rx_valid, rx_eop, rx_err}), 32'd0);
    endtask

    initial begin
        nRST = 1'b0;
        rx_enable = 1'b1;
        pulse = 1'b0;
        rx_dp = 1'b1;
        rx_se0 = 1'b0;
        lvl = 1'b1;
        tx_ones = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nRST = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");

        // Valid packet 0xA5, 0x3C
        send_j_n(2);
        send_sync();
        @(negedge clk);
        chk("active_after_sync", 32'(rx_active), 32'd1);
        chk("dec_en_in_packet", 32'(dec_en), 32'd1);
        expect_ev(EV_VALID, 8'hA5, 2'd0, 3);
        send_byte(8'hA5);
        expect_ev(EV_VALID, 8'h3C, 2'd0, 3);
        send_byte(8'h3C);
        expect_ev(EV_EOP, 8'h00, 2'd0, 1);
        send_eop();
        @(negedge clk);
        chk("active_after_eop", 32'(rx_active), 32'd0);

        // Stuffed 0xFF
        good_packet(8'hFF, 8'h81);

        // Stuff error: seven ones
        send_j_n(2);
        send_sync();
        expect_ev(EV_ERR, 8'h00, 2'd1, 3);
        for (int i = 0; i < 7; i++) send_dec(1'b1);
        @(negedge clk);
        chk("active_after_stufferr", 32'(rx_active), 32'd0);
        chk("dec_en_after_stufferr", 32'(dec_en), 32'd0);
        // Seven J then a would-be packet must still be ignored in ERROR
        send_j_n(7);
        send_sync();
        line_pulse(1'b1, 1'b0);
        line_pulse(1'b1, 1'b0);
        send_j_n(8);

        // Bad SYNC: six zeros then a one
        send_lvl(1'b0);
        for (int i = 0; i < 5; i++) send_dec(1'b0);
        expect_ev(EV_ERR, 8'h00, 2'd0, 3);
        send_dec(1'b1);
        @(negedge clk);
        chk("active_after_badsync", 32'(rx_active), 32'd0);
        send_j_n(8);

        // Bad SYNC: nine zeros, error on the eighth
        send_lvl(1'b0);
        for (int i = 0; i < 6; i++) send_dec(1'b0);
        expect_ev(EV_ERR, 8'h00, 2'd0, 3);
        send_dec(1'b0);
        send_dec(1'b0);
        send_j_n(8);

        // Partial byte at EOP
        send_sync();
        send_dec(1'b1);
        send_dec(1'b0);
        send_dec(1'b1);
        send_dec(1'b1);
        send_dec(1'b0);
        expect_ev(EV_ERR, 8'h00, 2'd2, 1);
        line_pulse(1'b1, 1'b0);
        line_pulse(1'b1, 1'b0);
        send_j_n(8);

        // Babble with MAX_BYTES = 2
        send_j_n(1);
        send_sync();
        expect_ev(EV_VALID, 8'h01, 2'd0, 3);
        send_byte(8'h01);
        expect_ev(EV_VALID, 8'h02, 2'd0, 3);
        send_byte(8'h02);
        expect_ev(EV_ERR, 8'h00, 2'd3, 3);
        send_byte(8'h03);
        line_pulse(1'b1, 1'b0);
        line_pulse(1'b1, 1'b0);
        send_j_n(8);

        // Reset mid-byte
        send_sync();
        expect_ev(EV_VALID, 8'hA5, 2'd0, 3);
        send_byte(8'hA5);
        for (int i = 0; i < 4; i++) send_dec(1'b1);
        @(posedge clk);
        #1;
        nRST = 1'b0;
        @(negedge clk);
        chk_reset_vals("midreset");
        repeat (2) @(posedge clk);
        #1;
        nRST = 1'b1;
        lvl = 1'b1;
        good_packet(8'hA5, 8'h3C);

        // rx_enable low mid-packet
        send_j_n(2);
        send_sync();
        expect_ev(EV_VALID, 8'h3C, 2'd0, 3);
        send_byte(8'h3C);
        for (int i = 0; i < 3; i++) send_dec(1'b0);
        @(posedge clk);
        #1;
        rx_enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("dis_dec_en", 32'(dec_en), 32'd0);
        chk("dis_dec_bit", 32'(dec_bit), 32'd1);
        chk("dis_rx_active", 32'(rx_active), 32'd0);
        send_j_n(2);
        send_sync();
        send_byte(8'h55);
        send_eop();
        rx_enable = 1'b1;
        good_packet(8'h12, 8'h34);

        repeat (20) @(posedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
